// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB full-speed receive path:
// receive FSM states, typed error codes and the default sync pattern.
package usb_rx_pkg;

    localparam logic [7:0] USB_SYNC_FS = 8'h80;

    typedef enum logic [3:0] {
        IDLE,
        BEGIN,
        WAIT_SYNC,
        CHECK_SYNC,
        WAIT_PID,
        CHECK_PID,
        WAIT_BYTE,
        STORE,
        EOP_CHECK,
        EOP_WAIT1,
        EOP_WAIT2,
        ERR_HOLD,
        ERR_EOP1,
        ERR_EOP2,
        ERR_IDLE
    } rx_state_t;

    typedef enum logic [2:0] {
        E_NONE      = 3'd0,
        E_SYNC      = 3'd1,
        E_PID       = 3'd2,
        E_EOP_ALIGN = 3'd3,
        E_OVERFLOW  = 3'd4,
        E_FIFO_FULL = 3'd5
    } rx_err_t;

endpackage

// File: rtl/pid_check.sv
// Combinational PID validator: the upper nibble must be the one's complement
// of the lower nibble. Shared between the RX and TX paths.
module pid_check (
    input  logic [7:0] data,
    output logic       valid,
    output logic [3:0] pid
);
    assign pid   = data[3:0];
    assign valid = (data[7:4] == ~data[3:0]);
endmodule

// File: rtl/usb_rx_pkt_ctrl.sv
// USB full-speed receive packet controller: sync/PID checking, payload
// storage with length limit and FIFO back-pressure, typed error reporting.
module usb_rx_pkt_ctrl
    import usb_rx_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = USB_SYNC_FS,
    parameter int         MAX_BYTES = 64,
    parameter int         CNT_W     = $clog2(MAX_BYTES + 1)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             d_edge,
    input  logic             eop,
    input  logic             shift_enable,
    input  logic [7:0]       rcv_data,
    input  logic             byte_received,
    input  logic [3:0]       bit_count,
    input  logic             fifo_full,
    output logic             rcving,
    output logic             w_enable,
    output logic             r_error,
    output logic [2:0]       err_code,
    output logic [3:0]       pid,
    output logic             pid_valid,
    output logic [CNT_W-1:0] byte_count,
    output logic             pkt_done
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BYTES);

    rx_state_t        state_reg, state_next;
    logic             rcving_reg, rcving_next;
    logic             w_enable_reg, w_enable_next;
    logic             r_error_reg, r_error_next;
    rx_err_t          err_reg, err_next;
    logic [3:0]       pid_reg, pid_next;
    logic             pid_valid_reg, pid_valid_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             pkt_done_reg, pkt_done_next;

    logic             pid_ok;
    logic [3:0]       pid_field;
    logic             start_pkt;
    logic             err_set;
    rx_err_t          err_new;
    logic             eop_strobe;

    pid_check u_pid_check (
        .data  (rcv_data),
        .valid (pid_ok),
        .pid   (pid_field)
    );

    assign eop_strobe = eop && shift_enable;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg     <= IDLE;
            rcving_reg    <= 1'b0;
            w_enable_reg  <= 1'b0;
            r_error_reg   <= 1'b0;
            err_reg       <= E_NONE;
            pid_reg       <= 4'd0;
            pid_valid_reg <= 1'b0;
            count_reg     <= '0;
            pkt_done_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            rcving_reg    <= rcving_next;
            w_enable_reg  <= w_enable_next;
            r_error_reg   <= r_error_next;
            err_reg       <= err_next;
            pid_reg       <= pid_next;
            pid_valid_reg <= pid_valid_next;
            count_reg     <= count_next;
            pkt_done_reg  <= pkt_done_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        rcving_next    = rcving_reg;
        w_enable_next  = 1'b0;
        r_error_next   = r_error_reg;
        err_next       = err_reg;
        pid_next       = pid_reg;
        pid_valid_next = pid_valid_reg;
        count_next     = count_reg;
        pkt_done_next  = 1'b0;
        start_pkt      = 1'b0;
        err_set        = 1'b0;
        err_new        = E_NONE;

        unique case (state_reg)
            IDLE: begin
                if (d_edge) begin
                    state_next = BEGIN;
                    start_pkt  = 1'b1;
                end
            end
            BEGIN: state_next = WAIT_SYNC;
            WAIT_SYNC: begin
                if (byte_received) state_next = CHECK_SYNC;
            end
            CHECK_SYNC: begin
                if (rcv_data == SYNC_BYTE) begin
                    state_next = WAIT_PID;
                end else begin
                    state_next = ERR_HOLD;
                    err_set    = 1'b1;
                    err_new    = E_SYNC;
                end
            end
            WAIT_PID: begin
                // A packet that ends before its PID arrives counts as a PID error.
                if (eop_strobe) begin
                    state_next = ERR_EOP1;
                    err_set    = 1'b1;
                    err_new    = E_PID;
                end else if (byte_received) begin
                    state_next = CHECK_PID;
                end
            end
            CHECK_PID: begin
                if (pid_ok) begin
                    state_next     = WAIT_BYTE;
                    pid_next       = pid_field;
                    pid_valid_next = 1'b1;
                end else begin
                    state_next = ERR_HOLD;
                    err_set    = 1'b1;
                    err_new    = E_PID;
                end
            end
            WAIT_BYTE: begin
                // EOP wins over a coincident byte; that byte is dropped.
                if (eop_strobe) begin
                    state_next = EOP_CHECK;
                end else if (byte_received && fifo_full) begin
                    state_next = ERR_HOLD;
                    err_set    = 1'b1;
                    err_new    = E_FIFO_FULL;
                end else if (byte_received && count_reg == MAX_CNT) begin
                    state_next = ERR_HOLD;
                    err_set    = 1'b1;
                    err_new    = E_OVERFLOW;
                end else if (byte_received) begin
                    state_next = STORE;
                end
            end
            STORE: begin
                w_enable_next = 1'b1;
                if (count_reg != MAX_CNT) count_next = count_reg + 1'b1;
                state_next = WAIT_BYTE;
            end
            EOP_CHECK: begin
                if (bit_count == 4'd1) begin
                    state_next = EOP_WAIT1;
                end else begin
                    state_next = ERR_EOP1;
                    err_set    = 1'b1;
                    err_new    = E_EOP_ALIGN;
                end
            end
            EOP_WAIT1: begin
                if (shift_enable) state_next = EOP_WAIT2;
            end
            EOP_WAIT2: begin
                if (shift_enable) begin
                    state_next    = IDLE;
                    rcving_next   = 1'b0;
                    pkt_done_next = 1'b1;
                end
            end
            ERR_HOLD: begin
                if (eop_strobe) state_next = ERR_EOP1;
            end
            ERR_EOP1: begin
                if (shift_enable) state_next = ERR_EOP2;
            end
            ERR_EOP2: begin
                if (shift_enable) begin
                    state_next  = ERR_IDLE;
                    rcving_next = 1'b0;
                end
            end
            ERR_IDLE: begin
                if (d_edge) begin
                    state_next = BEGIN;
                    start_pkt  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        if (start_pkt) begin
            rcving_next    = 1'b1;
            r_error_next   = 1'b0;
            err_next       = E_NONE;
            count_next     = '0;
            pid_valid_next = 1'b0;
        end

        // The first error of a packet sticks until the next packet starts.
        if (err_set && !r_error_reg) begin
            r_error_next = 1'b1;
            err_next     = err_new;
        end
    end

    assign rcving     = rcving_reg;
    assign w_enable   = w_enable_reg;
    assign r_error    = r_error_reg;
    assign err_code   = err_reg;
    assign pid        = pid_reg;
    assign pid_valid  = pid_valid_reg;
    assign byte_count = count_reg;
    assign pkt_done   = pkt_done_reg;

endmodule

// File: tb/tb_usb_rx_pkt_ctrl.sv
// Self-checking bench for usb_rx_pkt_ctrl: directed packets from the test plan
// plus randomized packets scored against a packet-level outcome model.
module tb_usb_rx_pkt_ctrl;

    localparam int         MAXB = 4;
    localparam int         CW   = $clog2(MAXB + 1);
    localparam logic [7:0] SYNC = 8'h80;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          d_edge = 1'b0;
    logic          eop = 1'b0;
    logic          shift_enable = 1'b0;
    logic [7:0]    rcv_data = 8'h00;
    logic          byte_received = 1'b0;
    logic [3:0]    bit_count = 4'd0;
    logic          fifo_full = 1'b0;
    logic          rcving;
    logic          w_enable;
    logic          r_error;
    logic [2:0]    err_code;
    logic [3:0]    pid;
    logic          pid_valid;
    logic [CW-1:0] byte_count;
    logic          pkt_done;

    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    logic [7:0] wr_q[$];
    int         done_cnt = 0;
    int         done_cyc = -1;
    int         fall_cyc = -2;
    logic       prev_rcving = 1'b0;
    logic [7:0] pay[8];
    logic [3:0] last_pid = 4'd0;

    usb_rx_pkt_ctrl #(.MAX_BYTES(MAXB)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .d_edge        (d_edge),
        .eop           (eop),
        .shift_enable  (shift_enable),
        .rcv_data      (rcv_data),
        .byte_received (byte_received),
        .bit_count     (bit_count),
        .fifo_full     (fifo_full),
        .rcving        (rcving),
        .w_enable      (w_enable),
        .r_error       (r_error),
        .err_code      (err_code),
        .pid           (pid),
        .pid_valid     (pid_valid),
        .byte_count    (byte_count),
        .pkt_done      (pkt_done)
    );

    always #5 clk = ~clk;

    // Observe outputs 2 ns after each edge; capture FIFO writes and pulses.
    always @(posedge clk) begin
        #2;
        cyc++;
        if (w_enable) wr_q.push_back(rcv_data);
        if (pkt_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (prev_rcving && !rcving) fall_cyc = cyc;
        prev_rcving = rcving;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Packet-level outcome derived from the protocol rules, not the FSM.
    function automatic void model(input logic [7:0] s, input logic [7:0] p, input int n,
                                  input int full_idx, input logic [3:0] ebc, input bit early,
                                  output int exp_wr, output int exp_err, output bit exp_pv);
        exp_wr = 0;
        exp_err = 0;
        exp_pv = 1'b0;
        if (s != SYNC) begin
            exp_err = 1;
        end else if (early || (p[7:4] != ~p[3:0])) begin
            exp_err = 2;
        end else begin
            exp_pv = 1'b1;
            for (int i = 0; i < n; i++) begin
                if (i == full_idx) begin
                    exp_err = 5;
                    break;
                end
                if (exp_wr == MAXB) begin
                    exp_err = 4;
                    break;
                end
                exp_wr++;
            end
            if (exp_err == 0 && ebc != 4'd1) exp_err = 3;
        end
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit full);
        rcv_data = b;
        byte_received = 1'b1;
        fifo_full = full;
        tick();
        byte_received = 1'b0;
        fifo_full = 1'b0;
        // d_edge and fifo_full noise between bytes must have no effect.
        repeat (3) begin
            d_edge = 1'($urandom_range(0, 1));
            fifo_full = 1'($urandom_range(0, 1));
            tick();
        end
        d_edge = 1'b0;
        fifo_full = 1'b0;
    endtask

    task automatic send_eop(input logic [3:0] bc, input bit collide, input logic [7:0] cb);
        bit_count = bc;
        eop = 1'b1;
        for (int k = 0; k < 3; k++) begin
            shift_enable = 1'b1;
            if (k == 0 && collide) begin
                rcv_data = cb;
                byte_received = 1'b1;
            end
            tick();
            shift_enable = 1'b0;
            byte_received = 1'b0;
            tick();
            tick();
        end
        eop = 1'b0;
        bit_count = 4'd0;
        tick();
        tick();
    endtask

    task automatic start_pkt();
        wr_q.delete();
        done_cnt = 0;
        done_cyc = -1;
        fall_cyc = -2;
        d_edge = 1'b1;
        tick();
        d_edge = 1'b0;
        chk("start_rcving", 32'(rcving), 32'd1);
        chk("start_r_error", 32'(r_error), 32'd0);
        chk("start_err_code", 32'(err_code), 32'd0);
        tick();
    endtask

    task automatic run_pkt(input logic [7:0] s, input logic [7:0] p, input int n,
                           input int full_idx, input logic [3:0] ebc, input bit early,
                           input bit collide);
        int exp_wr;
        int exp_err;
        bit exp_pv;
        model(s, p, n, full_idx, ebc, early, exp_wr, exp_err, exp_pv);
        if (exp_pv) last_pid = p[3:0];
        start_pkt();
        rcv_data = s;
        byte_received = 1'b1;
        tick();
        byte_received = 1'b0;
        chk("sync_not_early", 32'(r_error), 32'd0);
        tick();
        chk("sync_decision_r_error", 32'(r_error), 32'(s != SYNC));
        chk("sync_decision_code", 32'(err_code), (s != SYNC) ? 32'd1 : 32'd0);
        tick();
        tick();
        if (!early) begin
            send_byte(p, 1'b0);
            for (int i = 0; i < n; i++) send_byte(pay[i], i == full_idx);
        end
        send_eop(ebc, collide, 8'($urandom));
        $display("pkt sync=%02h pid=%02h n=%0d full=%0d ebc=%0d early=%0d col=%0d -> writes=%0d code=%0d cnt=%0d done=%0d",
                 s, p, n, full_idx, ebc, early, collide, wr_q.size(), err_code, byte_count, done_cnt);
        chk("writes", 32'(wr_q.size()), 32'(exp_wr));
        for (int i = 0; i < exp_wr && i < wr_q.size(); i++)
            chk("write_data", 32'(wr_q[i]), 32'(pay[i]));
        chk("err_code", 32'(err_code), 32'(exp_err));
        chk("r_error", 32'(r_error), 32'(exp_err != 0));
        chk("byte_count", 32'(byte_count), 32'(exp_wr));
        chk("pid_valid", 32'(pid_valid), 32'(exp_pv));
        chk("pid", 32'(pid), 32'(last_pid));
        chk("pkt_done_pulses", 32'(done_cnt), 32'(exp_err == 0));
        chk("rcving_end", 32'(rcving), 32'd0);
        if (exp_err == 0) chk("done_with_rcving_fall", 32'(done_cyc), 32'(fall_cyc));
        repeat (3) tick();
    endtask

    initial begin
        logic [3:0] q;
        logic [7:0] s;
        logic [7:0] p;
        int         n;
        int         fidx;
        logic [3:0] ebc;

        repeat (3) tick();
        chk("reset_outputs", 32'({rcving, w_enable, r_error, err_code, pid, pid_valid, byte_count, pkt_done}), 32'd0);
        n_rst = 1'b1;
        repeat (2) tick();

        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
        run_pkt(8'h80, 8'hC3, 3, -1, 4'd1, 1'b0, 1'b0);
        run_pkt(8'h81, 8'hC3, 3, -1, 4'd1, 1'b0, 1'b0);
        run_pkt(8'h80, 8'hC4, 3, -1, 4'd1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) pay[i] = 8'($urandom);
        run_pkt(8'h80, 8'hD2, 5, -1, 4'd1, 1'b0, 1'b0);
        run_pkt(8'h80, 8'hA5, 3, 1, 4'd1, 1'b0, 1'b0);
        run_pkt(8'h80, 8'h69, 2, -1, 4'd5, 1'b0, 1'b0);
        run_pkt(8'h80, 8'hE1, 0, -1, 4'd1, 1'b1, 1'b0);
        run_pkt(8'h80, 8'h4B, 2, -1, 4'd1, 1'b0, 1'b1);
        run_pkt(8'h80, 8'h0F, 4, -1, 4'd1, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a payload.
        start_pkt();
        send_byte(8'h80, 1'b0);
        send_byte(8'h96, 1'b0);
        send_byte(pay[0], 1'b0);
        send_byte(pay[1], 1'b0);
        chk("pre_reset_count", 32'(byte_count), 32'd2);
        #2;
        n_rst = 1'b0;
        #1;
        chk("async_reset_outputs", 32'({rcving, w_enable, r_error, err_code, pid, pid_valid, byte_count, pkt_done}), 32'd0);
        $display("async reset mid-payload -> rcving=%0d cnt=%0d pid_valid=%0d", rcving, byte_count, pid_valid);
        tick();
        n_rst = 1'b1;
        last_pid = 4'd0;
        repeat (2) tick();
        run_pkt(8'h80, 8'h3C, 2, -1, 4'd1, 1'b0, 1'b0);

        for (int t = 0; t < 30; t++) begin
            q = 4'($urandom);
            s = ($urandom_range(0, 9) < 8) ? SYNC : 8'($urandom);
            p = ($urandom_range(0, 9) < 8) ? {~q, q} : 8'($urandom);
            n = $urandom_range(0, 6);
            fidx = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 5)) : -1;
            ebc = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'd1;
            for (int i = 0; i < 8; i++) pay[i] = 8'($urandom);
            run_pkt(s, p, n, fidx, ebc, $urandom_range(0, 9) == 0, $urandom_range(0, 5) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
